// File: rtl/calc3_operand_sequencer.sv
//-----------------------------------------------------------------------------
// calc3_operand_sequencer
//
// Sequential front/back end for the combinational calculate3 datapath.
// Six operands arrive one per valid/ready beat. The sixth beat also carries a
// 2-bit mode. Operands and mode are held on N0..N5/MODE. OUT_N is sampled
// SETTLE edges after the last beat, and the sampled value is offered on a
// valid/ready result channel.
//
// Ports
//   CLK, RST_N       rising-edge clock, synchronous active-low reset
//   CLR              synchronous abort of the current transaction
//   IN_VALID/READY   operand beat handshake
//   IN_DATA/IN_MODE  operand value; mode (used on the sixth beat only)
//   N0..N5, MODE     operand/mode registers driven to calculate3
//   OUT_N            calculate3 result
//   RES_VALID/READY  result handshake
//   RES_DATA/MODE    captured OUT_N and the MODE that produced it
//   OP_CNT           beats accepted in the current transaction (0..5)
//   BUSY             high while settling or waiting for the result handshake
//-----------------------------------------------------------------------------
`timescale 1ns/1ps
module calc3_operand_sequencer #(
  parameter int OPW    = 6,
  parameter int RESW   = 10,
  parameter int SETTLE = 2   // legal range 1..15
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            CLR,
  input  logic            IN_VALID,
  output logic            IN_READY,
  input  logic [OPW-1:0]  IN_DATA,
  input  logic [1:0]      IN_MODE,
  output logic [OPW-1:0]  N0,
  output logic [OPW-1:0]  N1,
  output logic [OPW-1:0]  N2,
  output logic [OPW-1:0]  N3,
  output logic [OPW-1:0]  N4,
  output logic [OPW-1:0]  N5,
  output logic [1:0]      MODE,
  input  logic [RESW-1:0] OUT_N,
  output logic            RES_VALID,
  input  logic            RES_READY,
  output logic [RESW-1:0] RES_DATA,
  output logic [1:0]      RES_MODE,
  output logic [2:0]      OP_CNT,
  output logic            BUSY
);

  typedef enum logic [1:0] {ST_LOAD, ST_SETTLE, ST_RESP} state_t;

  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE - 1);

  state_t         state_q, state_d;
  logic [2:0]     idx_q;
  logic [3:0]     cnt_q;
  logic [OPW-1:0] n_q [6];
  logic           in_beat;
  logic           res_hs;

  // IN_READY also depends on RST_N so no beat appears accepted while in reset.
  assign IN_READY = RST_N && (state_q == ST_LOAD);
  assign BUSY     = (state_q != ST_LOAD);
  assign OP_CNT   = idx_q;
  assign in_beat  = IN_VALID && IN_READY;
  assign res_hs   = RES_VALID && RES_READY;

  assign N0 = n_q[0];
  assign N1 = n_q[1];
  assign N2 = n_q[2];
  assign N3 = n_q[3];
  assign N4 = n_q[4];
  assign N5 = n_q[5];

  // Next-state logic
  always_comb begin
    // NOTE: assign a default first so every path drives state_d and no latch is inferred.
    state_d = state_q;
    case (state_q)
      ST_LOAD:   if (in_beat && (idx_q == 3'd5)) state_d = ST_SETTLE;
      ST_SETTLE: if (cnt_q == 4'd0)              state_d = ST_RESP;
      ST_RESP:   if (res_hs)                     state_d = ST_LOAD;
      default:                                   state_d = ST_LOAD;
    endcase
    if (CLR) state_d = ST_LOAD;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples values from before the edge regardless of block ordering.
  always_ff @(posedge CLK) begin
    if (!RST_N) state_q <= ST_LOAD;
    else        state_q <= state_d;
  end

  // Datapath: operand, mode, counter and result registers
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      // NOTE: the six operand registers are reset because they drive visible
      // outputs that must read zero after reset. They are discrete flops, not RAM.
      for (int i = 0; i < 6; i++) n_q[i] <= '0;
      idx_q     <= 3'd0;
      cnt_q     <= 4'd0;
      MODE      <= 2'd0;
      RES_VALID <= 1'b0;
      RES_DATA  <= '0;
      RES_MODE  <= 2'd0;
    end else if (CLR) begin
      // Abort only: operand, mode and result registers are retained.
      idx_q     <= 3'd0;
      cnt_q     <= 4'd0;
      RES_VALID <= 1'b0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (in_beat) begin
            for (int i = 0; i < 6; i++) begin
              if (idx_q == 3'(i)) n_q[i] <= IN_DATA;
            end
            if (idx_q == 3'd5) begin
              MODE  <= IN_MODE;
              idx_q <= 3'd0;
              cnt_q <= SETTLE_INIT;
            end else begin
              idx_q <= idx_q + 3'd1;
            end
          end
        end
        ST_SETTLE: begin
          // cnt_q == 0 marks the edge SETTLE edges after the last beat.
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            RES_DATA  <= OUT_N;
            RES_MODE  <= MODE;
            RES_VALID <= 1'b1;
          end
        end
        ST_RESP: begin
          if (res_hs) RES_VALID <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
